// File: rtl/perf_stat_display_pkg.sv
// Shared definitions for the performance-counter display block: select codes,
// counter slot indices and the active-low seven-segment glyph table.
package perf_stat_display_pkg;

    localparam logic [2:0] PERF_SEL_DISPLAY  = 3'd0;
    localparam logic [2:0] PERF_SEL_CYCLES   = 3'd1;
    localparam logic [2:0] PERF_SEL_JUMP     = 3'd2;
    localparam logic [2:0] PERF_SEL_BRANCH   = 3'd3;
    localparam logic [2:0] PERF_SEL_TAKEN    = 3'd4;
    localparam logic [2:0] PERF_SEL_NOP      = 3'd5;
    localparam logic [2:0] PERF_SEL_DBP_HIT  = 3'd6;
    localparam logic [2:0] PERF_SEL_DBP_MISS = 3'd7;

    localparam int NUM_CNT = 8;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // gfedcba, active-low, entry N is the glyph for hex digit N
    localparam logic [15:0][6:0] SEG_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Slot 0 is the display word, so counter slots line up with the sel codes
    typedef enum logic [2:0] {
        CNT_DISPLAY  = 3'd0,
        CNT_CYCLES   = 3'd1,
        CNT_JUMP     = 3'd2,
        CNT_BRANCH   = 3'd3,
        CNT_TAKEN    = 3'd4,
        CNT_NOP      = 3'd5,
        CNT_DBP_HIT  = 3'd6,
        CNT_DBP_MISS = 3'd7
    } cnt_idx_e;

endpackage

// File: rtl/perf_stat_display_seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern (dp always off).
module seg7_hex_decode
    import perf_stat_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    assign o_seg = i_blank ? SEG_BLANK : {1'b1, SEG_GLYPH[i_nibble]};

endmodule

// File: rtl/perf_stat_display.sv
// Saturating CPU performance counters with halt freeze, value select and a
// multiplexed 8-digit hex display. Optional macro PERF_LZ_BLANK_EN blanks leading zeros.
module perf_stat_display
    import perf_stat_display_pkg::*;
#(
    parameter int CntWidth = 32,
    parameter int ScanDiv  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic        halt,
    input  logic        is_jump,
    input  logic        is_branch,
    input  logic        branched,
    input  logic        is_nop,
    input  logic        dbp_hit,
    input  logic        dbp_miss,
    input  logic [31:0] display,
    input  logic [2:0]  sel,
    output logic [31:0] value,
    output logic [7:0]  seg,
    output logic [7:0]  an
);

    logic                 r_halted;
    logic                 w_cnt_en;
    logic [NUM_CNT-1:1]   w_evt;
    logic [31:0]          w_src [NUM_CNT];
    logic [31:0]          r_value;

    // The halting cycle itself still counts; the latch gates from the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   r_halted <= 1'b0;
        else if (clr) r_halted <= 1'b0;
        else          r_halted <= r_halted | (en & halt);
    end

    assign w_cnt_en = en & ~r_halted;

    assign w_evt[CNT_CYCLES]   = 1'b1;
    assign w_evt[CNT_JUMP]     = is_jump;
    assign w_evt[CNT_BRANCH]   = is_branch;
    assign w_evt[CNT_TAKEN]    = branched;
    assign w_evt[CNT_NOP]      = is_nop;
    assign w_evt[CNT_DBP_HIT]  = dbp_hit;
    assign w_evt[CNT_DBP_MISS] = dbp_miss;

    assign w_src[CNT_DISPLAY] = display;

    for (genvar i = 1; i < NUM_CNT; i++) begin : g_cnt
        logic [CntWidth-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_cnt <= '0;
            else if (clr)
                r_cnt <= '0;
            else if (w_cnt_en && w_evt[i] && (r_cnt != '1))
                r_cnt <= r_cnt + CntWidth'(1);
        end

        if (CntWidth >= 32) begin : g_trunc
            assign w_src[i] = r_cnt[31:0];
        end else begin : g_zext
            assign w_src[i] = {{(32 - CntWidth){1'b0}}, r_cnt};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_value <= '0;
        else        r_value <= w_src[sel];
    end

    assign value = r_value;

    logic [ScanDiv-1:0] r_presc;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_nxt;
    logic [3:0]         w_nib;
    logic               w_blank;
    logic [7:0]         w_seg;
    logic [7:0]         r_seg;
    logic [7:0]         r_an;

    // seg/an are registered from the next index so they move with the index
    assign w_idx_nxt = (en && (r_presc == '1)) ? r_idx + 3'd1 : r_idx;
    assign w_nib     = r_value[{w_idx_nxt, 2'b00} +: 4];

`ifdef PERF_LZ_BLANK_EN
    logic [2:0] w_msn;

    always_comb begin
        w_msn = 3'd0;
        for (int k = 1; k < 8; k++)
            if (r_value[4*k +: 4] != 4'h0) w_msn = 3'(k);
    end

    assign w_blank = (w_idx_nxt > w_msn);
`else
    assign w_blank = 1'b0;
`endif

    seg7_hex_decode u_dec (
        .i_nibble (w_nib),
        .i_blank  (w_blank),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= 3'd0;
            r_an    <= 8'hFE;
            r_seg   <= 8'hC0;
        end else begin
            if (en) r_presc <= r_presc + ScanDiv'(1);
            r_idx <= w_idx_nxt;
            r_an  <= ~(8'd1 << w_idx_nxt);
            r_seg <= w_seg;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule
